output_port_arbiter: RTL and testbench
======================================

OUTPUT_PORT_ARBITER -- requirements
Module: output_port_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, is the number of input-VC requesters sharing one output port (2..8).
REQ-002 Parameter MAX_CREDITS, default 4, is the downstream buffer depth in flits (1..15).
REQ-003 Parameter IDXW, default $clog2(NUM_REQ), is the width of the winner index.
REQ-004 Timing and reset: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 req  input  NUM_REQ  bit i set means requester i holds a flit for this port.
REQ-008 req_tail  input  NUM_REQ  bit i set means requester i's current flit is a tail (single-flit packet: head=tail=1).
REQ-009 credit_in  input  1  one-cycle pulse; downstream freed one buffer slot.
REQ-010 grant  output  NUM_REQ  one-hot or zero; combinational grant for the current cycle.
REQ-011 grant_valid  output  1  OR of grant; a flit transfers this cycle.
REQ-012 grant_idx  output  IDXW  index of the granted requester; 0 when grant_valid=0.
REQ-013 pipe_enable  output  1  equals grant_valid; drives the enable of the output-stage pipeline register.
REQ-014 credits  output  $clog2(MAX_CREDITS+1)  registered count of available downstream slots.
REQ-015 locked  output  1  registered; 1 while a multi-flit packet owns the port.

Function
REQ-016 A transfer occurs in a cycle only when grant_valid=1; grant_valid=1 requires credits>0.
REQ-017 State IDLE: the winner is the first set bit of req, searched circularly from rr_ptr upward; no set bit gives no grant.
REQ-018 In IDLE, a transfer with req_tail[winner]=0 moves to LOCKED with owner<=winner; rr_ptr is unchanged.
REQ-019 In IDLE, a transfer with req_tail[winner]=1 stays IDLE; rr_ptr<=(winner+1) mod NUM_REQ.
REQ-020 In LOCKED, only the owner is granted, when req[owner]=1 and credits>0; other requests are ignored.
REQ-021 In LOCKED, a transfer with req_tail[owner]=1 moves to IDLE; rr_ptr<=(owner+1) mod NUM_REQ.
REQ-022 In LOCKED, if req[owner] drops, the block stays LOCKED with no grant (wormhole hold).
REQ-023 Credits: a transfer decrements and credit_in increments; both in the same cycle leave the count unchanged.
REQ-024 credit_in at credits=MAX_CREDITS with no transfer is ignored, and the count saturates; the block flags it with a simulation-only assertion.
REQ-025 credits=0 blocks all grants in both states; the state does not change.
REQ-026 Latency: grant is combinational from req, req_tail, state and credits (zero cycles); the state, rr_ptr and credits update at the next rising edge.

Reset
REQ-027 While reset_n=0: state=IDLE, locked=0, rr_ptr=0, owner=0, credits=MAX_CREDITS.
REQ-028 Registered outputs take their reset values immediately on reset_n falling, independent of clk.
REQ-029 Reset asserted mid-packet abandons the lock; there is no recovery of a partial packet.
REQ-030 The first edge after reset_n rises behaves as IDLE with rr_ptr=0.

Structure
REQ-031 A shared package holds the arb_state_e enum (IDLE, LOCKED) and the default NUM_REQ and MAX_CREDITS constants.
REQ-032 A single sub-module rr_priority_pick (combinational, circular first-one from a pointer) is instantiated once.
REQ-033 The credit counter and the lock FSM live in the top module; the pipeline register stays external and is fed by pipe_enable.

Verification
REQ-034 NUM_REQ=4, req=4'b1010 with all tails set, held for 4 cycles -> grants 1,3,1,3; rr_ptr goes 2,0,2,0.
REQ-035 Req 0 sends a 3-flit packet (tail on flit 3) while req 2 is also asserted -> grant_idx=0 for 3 transfers with locked=1, then grant_idx=2.
REQ-036 MAX_CREDITS=4, continuous single-flit traffic with no credit_in -> 4 grants, then grant_valid=0 with credits=0; one credit_in -> exactly 1 more grant.
REQ-037 Simultaneous transfer and credit_in at credits=2 -> credits stays 2.
REQ-038 Owner drops req for 2 cycles mid-packet -> no grant, locked=1; resumes to the tail, then IDLE.
REQ-039 reset_n pulsed low asynchronously mid-packet -> locked=0, credits=4 and grant_valid=0 before the next edge; next grant follows rr_ptr=0.

Source files
------------

// File: rtl/output_port_arbiter_pkg.sv
// output_port_arbiter_pkg: shared state type and default sizing for the output port arbiter
package output_port_arbiter_pkg;
  typedef enum logic {IDLE, LOCKED} arb_state_e;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_MAX_CREDITS = 4;
endpackage

// File: rtl/output_port_arbiter_rr_priority_pick.sv
// rr_priority_pick: circular first-one search over req_i starting at ptr_i
module rr_priority_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         valid_o,
  output logic [W-1:0] idx_o
);
  always_comb begin
    valid_o = |req_i;
    idx_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[W'((int'(ptr_i) + k) % N)]) idx_o = W'((int'(ptr_i) + k) % N);
    end
  end
endmodule

// File: rtl/output_port_arbiter.sv
// output_port_arbiter: credit-gated round-robin wormhole arbiter for one output port
module output_port_arbiter
  import output_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int MAX_CREDITS = DEF_MAX_CREDITS,
  parameter int IDXW = $clog2(NUM_REQ),
  localparam int CW = $clog2(MAX_CREDITS + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_tail,
  input  logic               credit_in,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [IDXW-1:0]    grant_idx,
  output logic               pipe_enable,
  output logic [CW-1:0]      credits,
  output logic               locked
);
  arb_state_e state_q, state_d;
  logic [IDXW-1:0] owner_q, owner_d, rr_ptr_q, rr_ptr_d, pick_idx, win_idx, nxt_ptr;
  logic [CW-1:0] credits_q, credits_d;
  logic pick_valid, win_valid;
  rr_priority_pick #(.N(NUM_REQ), .W(IDXW)) u_pick (
    .req_i(req),
    .ptr_i(rr_ptr_q),
    .valid_o(pick_valid),
    .idx_o(pick_idx)
  );
  // grants are suppressed while reset is held so nothing transfers from a stale request
  always_comb begin
    win_idx = (state_q == LOCKED) ? owner_q : pick_idx;
    win_valid = reset_n && (credits_q != '0) && ((state_q == LOCKED) ? req[owner_q] : pick_valid);
    grant = '0;
    grant[win_idx] = win_valid;
    grant_idx = win_valid ? win_idx : '0;
    nxt_ptr = (win_idx == IDXW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    state_d = state_q;
    owner_d = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (win_valid && req_tail[win_idx]) begin
      state_d = IDLE;
      rr_ptr_d = nxt_ptr;
    end else if (win_valid) begin
      state_d = LOCKED;
      owner_d = win_idx;
    end
    credits_d = (win_valid && !credit_in) ? credits_q - 1'b1 :
                (!win_valid && credit_in && credits_q != CW'(MAX_CREDITS)) ? credits_q + 1'b1 : credits_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_ptr_q <= '0;
      credits_q <= CW'(MAX_CREDITS);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      credits_q <= credits_d;
    end
  end
  assign grant_valid = win_valid;
  assign pipe_enable = win_valid;
  assign credits = credits_q;
  assign locked = (state_q == LOCKED);
`ifndef SYNTHESIS
  credit_overflow_a: assert property (@(posedge clk) disable iff (!reset_n)
    !(credit_in && !win_valid && credits_q == CW'(MAX_CREDITS)));
`endif
endmodule

// File: tb/tb_output_port_arbiter.sv
// tb_output_port_arbiter: directed and random checks against a behavioural arbiter model
module tb_output_port_arbiter;
  localparam int N = 4;
  localparam int MC = 4;
  logic clk = 0, reset_n = 1, credit_in = 0;
  logic [3:0] req = '0, req_tail = '0, grant;
  logic grant_valid, pipe_enable, locked;
  logic [1:0] grant_idx;
  logic [2:0] credits;
  int checks = 0, errors = 0;
  int m_locked, m_owner, m_ptr, m_cred, e_v, e_i, obs_v, obs_i, obs_l, obs_c;

  output_port_arbiter #(.NUM_REQ(N), .MAX_CREDITS(MC)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_tail(req_tail), .credit_in(credit_in),
    .grant(grant), .grant_valid(grant_valid), .grant_idx(grant_idx), .pipe_enable(pipe_enable),
    .credits(credits), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset;
    m_locked = 0; m_owner = 0; m_ptr = 0; m_cred = MC;
  endtask

  task automatic model_pick(input logic [3:0] r);
    e_v = 0; e_i = 0;
    if (m_cred == 0) return;
    if (m_locked != 0) begin
      e_v = int'(r[m_owner]); e_i = m_owner;
    end else begin
      for (int k = 0; k < N; k++) begin
        int j = (m_ptr + k) % N;
        if (r[j]) begin e_v = 1; e_i = j; break; end
      end
    end
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] t, input logic ci);
    @(negedge clk);
    req = r; req_tail = t; credit_in = ci;
    #1;
    model_pick(r);
    chk("grant_valid", int'(grant_valid), e_v);
    chk("grant_idx", int'(grant_idx), e_v != 0 ? e_i : 0);
    chk("grant", int'(grant), e_v != 0 ? (1 << e_i) : 0);
    chk("pipe_enable", int'(pipe_enable), e_v);
    chk("credits", int'(credits), m_cred);
    chk("locked", int'(locked), m_locked);
    obs_v = int'(grant_valid); obs_i = int'(grant_idx); obs_l = int'(locked); obs_c = int'(credits);
    @(posedge clk);
    if (e_v != 0) begin
      if (t[e_i]) begin m_locked = 0; m_ptr = (e_i + 1) % N; end
      else begin m_locked = 1; m_owner = e_i; end
    end
    m_cred = m_cred - e_v + int'(ci);
    if (m_cred > MC) m_cred = MC;
  endtask

  initial begin
    logic [3:0] r, t;
    logic ci;
    int cnt;
    model_reset;
    #1 reset_n = 0;
    #2;
    chk("rst_locked", int'(locked), 0);
    chk("rst_credits", int'(credits), MC);
    chk("rst_grant_valid", int'(grant_valid), 0);
    @(negedge clk); reset_n = 1;
    for (int i = 0; i < 4; i++) begin
      step(4'b1010, 4'b1111, 1'b1);
      chk("rr_seq", obs_i, (i % 2) != 0 ? 3 : 1);
    end
    step(4'b0101, 4'b0100, 1'b1); chk("pkt_f1", obs_i, 0);
    step(4'b0101, 4'b0100, 1'b1); chk("pkt_f2", obs_i, 0); chk("pkt_lock2", obs_l, 1);
    step(4'b0101, 4'b0101, 1'b1); chk("pkt_f3", obs_i, 0); chk("pkt_lock3", obs_l, 1);
    step(4'b0100, 4'b0100, 1'b1); chk("pkt_next", obs_i, 2); chk("pkt_unlock", obs_l, 0);
    step(4'b0010, 4'b0000, 1'b1); chk("hold_head", obs_i, 1);
    for (int i = 0; i < 2; i++) begin
      step(4'b1000, 4'b1000, 1'b0);
      chk("hold_nogrant", obs_v, 0); chk("hold_locked", obs_l, 1);
    end
    step(4'b0010, 4'b0000, 1'b1); chk("hold_resume", obs_i, 1);
    step(4'b0010, 4'b0010, 1'b1); chk("hold_tail", obs_i, 1);
    step(4'b0000, 4'b0000, 1'b0); chk("hold_idle", obs_l, 0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin step(4'b1111, 4'b1111, 1'b0); cnt += obs_v; end
    chk("cred_grants", cnt, 4); chk("cred_zero", obs_c, 0);
    step(4'b1111, 4'b1111, 1'b1); chk("cred_blocked", obs_v, 0);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin step(4'b1111, 4'b1111, 1'b0); cnt += obs_v; end
    chk("cred_one_more", cnt, 1);
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b0001, 4'b0001, 1'b1); chk("cred_at2", obs_c, 2);
    step(4'b0000, 4'b0000, 1'b0); chk("cred_same", obs_c, 2);
    step(4'b0100, 4'b0000, 1'b1);
    step(4'b0100, 4'b0000, 1'b1); chk("rst_pkt_locked", obs_l, 1);
    @(negedge clk);
    #3 reset_n = 0;
    #1;
    chk("arst_locked", int'(locked), 0);
    chk("arst_credits", int'(credits), MC);
    chk("arst_grant_valid", int'(grant_valid), 0);
    model_reset;
    #2 reset_n = 1;
    step(4'b1111, 4'b1111, 1'b1); chk("post_rst_idx", obs_i, 0);
    for (int i = 0; i < 400; i++) begin
      r = 4'($urandom);
      t = 4'($urandom);
      model_pick(r);
      ci = (m_cred < MC || e_v != 0) ? 1'($urandom) : 1'b0;
      step(r, t, ci);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
